// File: rtl/mult_arbiter.sv
// Shares one LAT-cycle pipelined multiplier among NREQ requesters; round-robin, or lowest-index-wins when MULT_ARB_FIXED_PRIO_EN is defined.
// Handshake to res_valid takes LAT+2 cycles; issue stalls on credit, so the non-stallable multiplier never overflows the result FIFO.
module mult_arbiter #(
   parameter  int DIM   = 8,
   parameter  int NREQ  = 4,
   parameter  int LAT   = 3,
   parameter  int DEPTH = 8,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*DIM-1:0]   req_a,
   input  logic [NREQ*DIM-1:0]   req_b,
   output logic                  mul_valid,
   output logic [DIM-1:0]        mul_a,
   output logic [DIM-1:0]        mul_b,
   input  logic [2*DIM-1:0]      mul_p,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [2*DIM-1:0]      res_p,
   output logic [IDW-1:0]        res_id
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(DEPTH + LAT + 2);

   logic [IDW-1:0]   ptr_q, ptr_d;
   logic             mul_valid_q, mul_valid_d;
   logic [DIM-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [IDW-1:0]   iss_id_q, iss_id_d;
   logic [LAT-1:0]   tag_vld_q, tag_vld_d;
   logic [IDW-1:0]   tag_id_q [LAT];
   logic [IDW-1:0]   tag_id_d [LAT];
   logic [2*DIM-1:0] fifo_p_q [DEPTH];
   logic [2*DIM-1:0] fifo_p_d [DEPTH];
   logic [IDW-1:0]   fifo_id_q [DEPTH];
   logic [IDW-1:0]   fifo_id_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [OW-1:0]    outstanding;
   logic [IDW:0]     cand;
   logic [IDW-1:0]   win;
   logic             found, issue_ok, hs, push, pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Everything issued but not yet popped holds a FIFO slot in reserve.
   always_comb begin
      outstanding = OW'(cnt_q) + OW'(mul_valid_q);
      for (int i = 0; i < LAT; i++) outstanding = outstanding + OW'(tag_vld_q[i]);
   end

   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
         if (!found && req_valid[cand[IDW-1:0]]) begin
            found = 1'b1;
            win   = cand[IDW-1:0];
         end
      end
   end

   assign issue_ok  = outstanding < OW'(DEPTH);
   assign hs        = found & issue_ok;
   assign req_ready = hs ? (NREQ'(1) << win) : '0;

   always_comb begin
      ptr_d       = ptr_q;
      mul_valid_d = hs;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      iss_id_d    = iss_id_q;
      if (hs) begin
         for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
               mul_a_d = req_a[i*DIM +: DIM];
               mul_b_d = req_b[i*DIM +: DIM];
            end
         end
         iss_id_d = win;
`ifdef MULT_ARB_FIXED_PRIO_EN
         ptr_d = '0;
`else
         ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
`endif
      end
   end

   // Tag stage 0 follows the issue register, so the last stage lines up with mul_p.
   always_comb begin
      tag_vld_d[0] = mul_valid_q;
      tag_id_d[0]  = iss_id_q;
      for (int i = 1; i < LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end
   end

   assign push = tag_vld_q[LAT-1];
   assign pop  = res_valid & res_ready;

   always_comb begin
      fifo_p_d  = fifo_p_q;
      fifo_id_d = fifo_id_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      if (push) begin
         fifo_p_d[wr_ptr_q]  = mul_p;
         fifo_id_d[wr_ptr_q] = tag_id_q[LAT-1];
         wr_ptr_d            = nxt(wr_ptr_q);
      end
      if (pop) rd_ptr_d = nxt(rd_ptr_q);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ptr_q       <= '0;
         mul_valid_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         iss_id_q    <= '0;
         tag_vld_q   <= '0;
         for (int i = 0; i < LAT; i++) tag_id_q[i] <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_p_q[i]  <= '0;
            fifo_id_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         ptr_q       <= ptr_d;
         mul_valid_q <= mul_valid_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         iss_id_q    <= iss_id_d;
         tag_vld_q   <= tag_vld_d;
         tag_id_q    <= tag_id_d;
         fifo_p_q    <= fifo_p_d;
         fifo_id_q   <= fifo_id_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   fifo_no_overflow: assert property (@(posedge clk) disable iff (!n_rst)
      !(push && cnt_q == CW'(DEPTH)));

   assign mul_valid = mul_valid_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign res_valid = (cnt_q != '0);
   assign res_p     = fifo_p_q[rd_ptr_q];
   assign res_id    = fifo_id_q[rd_ptr_q];

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural LAT-cycle multiplier, result scoreboard, directed vectors.
module tb_mult_arbiter;
   localparam int DIM = 8, NREQ = 4, LAT = 3, DEPTH = 8;

   logic                clk = 1'b0;
   logic                n_rst;
   logic [NREQ-1:0]     req_valid, req_ready;
   logic [NREQ*DIM-1:0] req_a, req_b;
   logic                mul_valid;
   logic [DIM-1:0]      mul_a, mul_b;
   logic [2*DIM-1:0]    mul_p;
   logic                res_valid, res_ready;
   logic [2*DIM-1:0]    res_p;
   logic [1:0]          res_id;

   always #5 clk = ~clk;

   mult_arbiter #(.DIM(DIM), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .n_rst(n_rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_id(res_id)
   );

   // External multiplier: product of the operands presented at cycle t appears at t+LAT.
   logic [15:0] mpipe [LAT];
   always @(posedge clk) begin
      mpipe[0] <= 16'(mul_a) * 16'(mul_b);
      for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
   end
   assign mul_p = mpipe[LAT-1];

   typedef struct packed { logic [15:0] p; logic [1:0] id; } res_t;
   typedef struct { int id; logic [7:0] a; logic [7:0] b; logic [15:0] p; } vec_t;

   res_t exp_q[$];
   int   n_cmp = 0, n_bad = 0;
   int   cur_i, hs_cnt, exp_ptr, g;
   logic hs;
   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Checks any pop due at the coming edge, then advances to 1 time unit after it.
   task automatic cyc();
      res_t e;
      if (n_rst && res_valid && res_ready) begin
         chk("sb_expected_any", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_p", res_p, e.p);
            chk("sb_id", res_id, e.id);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_req_ready"}, req_ready, 0);
      chk({nm, "_mul_valid"}, mul_valid, 0);
      chk({nm, "_mul_a"}, mul_a, 0);
      chk({nm, "_mul_b"}, mul_b, 0);
      chk({nm, "_res_valid"}, res_valid, 0);
      chk({nm, "_res_p"}, res_p, 0);
      chk({nm, "_res_id"}, res_id, 0);
   endtask

   task automatic drain(input string nm);
      for (int k = 0; k < 60; k++) begin
         cyc();
         req_valid = '0;
         res_ready = 1'b1;
         if (exp_q.size() == 0) break;
      end
      chk(nm, exp_q.size(), 0);
   endtask

   task automatic run_single(input vec_t v);
      cyc();
      res_ready = 1'b1;
      req_valid = '0;
      req_valid[v.id] = 1'b1;
      req_a[v.id*8 +: 8] = v.a;
      req_b[v.id*8 +: 8] = v.b;
      #1;
      chk("single_grant", req_ready, 32'(1 << v.id));
      exp_q.push_back(res_t'{v.p, 2'(v.id)});
      cyc();
      req_valid = '0;
      #1;
      chk("single_mul_valid", mul_valid, 1);
      chk("single_mul_a", mul_a, v.a);
      chk("single_mul_b", mul_b, v.b);
      for (int c = 2; c <= LAT + 2; c++) begin
         cyc();
         #1;
         chk("single_res_valid_timing", res_valid, 32'(c == LAT + 2));
      end
      chk("single_res_p", res_p, v.p);
      chk("single_res_id", res_id, v.id);
   endtask

   task automatic step(input logic rr);
      cyc();
      res_ready = rr;
      req_valid = (cur_i <= 20) ? 4'b0001 : 4'b0000;
      req_a[7:0] = 8'(cur_i);
      req_b[7:0] = 8'd3;
      #1;
      hs = req_valid[0] & req_ready[0];
      if (hs) begin
         exp_q.push_back(res_t'{16'(3 * cur_i), 2'd0});
         hs_cnt++;
         cur_i++;
      end
   endtask

   initial begin
      vecs[0] = '{2, 8'hFF, 8'hFF, 16'hFE01};
      vecs[1] = '{0, 8'h00, 8'hA5, 16'h0000};
      vecs[2] = '{3, 8'h80, 8'h80, 16'h4000};
      vecs[3] = '{1, 8'h12, 8'h34, 16'h03A8};
      vecs[4] = '{3, 8'hA5, 8'h00, 16'h0000};
      vecs[5] = '{0, 8'h01, 8'hFF, 16'h00FF};

      n_rst = 1'b0;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_rst = 1'b1;
      #1;
      chk_reset_outs("por");

      // All requesters valid, one grant per cycle in rotation.
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*8 +: 8] = 8'(8'h10 + i);
         req_b[i*8 +: 8] = 8'(8'h02 + i);
      end
      exp_ptr = 0;
      for (int c = 0; c < 12; c++) begin
         cyc();
         res_ready = 1'b1;
         req_valid = 4'hF;
         #1;
`ifdef MULT_ARB_FIXED_PRIO_EN
         g = 0;
`else
         g = exp_ptr;
`endif
         chk("arb_grant", req_ready, 32'(1 << g));
         exp_q.push_back(res_t'{16'((16 + g) * (2 + g)), 2'(g)});
         exp_ptr = (g + 1) % NREQ;
      end
      drain("arb_drain");

      foreach (vecs[i]) run_single(vecs[i]);
      drain("single_drain");

      // Backpressure: exactly DEPTH issues, then the pop-credit timing.
      cur_i = 1;
      hs_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         step(1'b0);
         chk("bp_issue", hs, 1);
      end
      for (int c = 0; c < 12; c++) begin
         step(1'b0);
         chk("bp_stall", hs, 0);
      end
      chk("bp_count", hs_cnt, DEPTH);
      chk("bp_res_valid", res_valid, 1);
      step(1'b1);
      chk("pop_same_cycle_no_grant", hs, 0);
      step(1'b0);
      chk("pop_next_cycle_grant", hs, 1);
      for (int c = 0; c < 3; c++) begin
         step(1'b0);
         chk("pop_after_no_grant", hs, 0);
      end
      for (int k = 0; k < 300 && (cur_i <= 20 || exp_q.size() != 0); k++) step(1'b1);
      chk("bp_all_issued", cur_i, 21);
      chk("bp_drained", exp_q.size(), 0);

      // Reset with three operations in flight.
      for (int c = 0; c < 3; c++) begin
         cyc();
         res_ready = 1'b1;
         req_valid = 4'(1 << c);
         req_a[c*8 +: 8] = 8'(8'h20 + c);
         req_b[c*8 +: 8] = 8'h03;
         #1;
         chk("rst_pre_grant", req_ready, 32'(1 << c));
      end
      cyc();
      req_valid = '0;
      cyc();
      chk("rst_pre_res_valid", res_valid, 0);
      n_rst = 1'b0;
      exp_q.delete();
      #1;
      chk_reset_outs("in_reset");
      cyc();
      cyc();
      n_rst = 1'b1;
      #1;
      chk_reset_outs("post_reset");
      for (int c = 0; c < LAT + 4; c++) begin
         cyc();
         #1;
         chk("rst_no_res_valid", res_valid, 0);
         chk("rst_no_mul_valid", mul_valid, 0);
      end
      run_single('{1, 8'h0F, 8'h11, 16'h00FF});
      drain("final_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
